// File: rtl/map_port_arbiter.sv
// ---------------------------------------------------------------------------
// map_port_arbiter
//
// Shares a single map BRAM port between NUM_REQ requesters with round-robin
// arbitration. The arbiter also sequences a full map restore from the init
// image. It fires a one-cycle mem_soft_rst pulse at the BRAM reload
// sequencer, then holds off all grants while the reload runs.
//
// Ports
//   clk           single clock, everything on posedge
//   rst           synchronous active-high reset (starts a reload on release)
//   reload_req    one-cycle pulse requesting a map restore
//   req/we        per-requester request and write flag
//   addr/wdata    per-requester address / write data, slot i at [i*W +: W]
//   gnt           one-hot/zero grant, combinational, in the access cycle
//   rvalid        one-hot/zero read-return strobe, one cycle after a read gnt
//   rdata         BRAM read data pass-through, qualified by rvalid
//   busy          high while a map reload is in progress
//   ram_we/ram_addr/ram_di  BRAM port drive from the granted slot
//   ram_do        BRAM read data (one-cycle latency)
//   mem_soft_rst  registered one-cycle pulse to the BRAM reload sequencer
// ---------------------------------------------------------------------------
module map_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int DATA_DEPTH = 1023,
    localparam int AW        = $clog2(DATA_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            reload_req,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              we,
    input  logic [NUM_REQ*AW-1:0]           addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            busy,
    output logic                            ram_we,
    output logic [AW-1:0]                   ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_di,
    input  logic [DATA_WIDTH-1:0]           ram_do,
    output logic                            mem_soft_rst
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(DATA_DEPTH + 2);
    // The wait phase covers count values 0..DATA_DEPTH, i.e. the reload
    // duration plus one cycle of margin before grants resume.
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_SERVE       = 2'd0,
        ST_RELOAD_KICK = 2'd1,
        ST_RELOAD_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       w_ptr_next;
    logic [NUM_REQ-1:0]  r_rvalid;
    logic                r_mem_soft_rst;

    logic                w_grant_en;
    logic                w_found;
    logic [PW-1:0]       w_gnt_idx;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [PW-1:0]       w_rr_idx [NUM_REQ];
    logic [AW-1:0]         w_addr_m [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_di_m   [NUM_REQ];
    logic [NUM_REQ-1:0]    w_we_m;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RELOAD_KICK;
            r_cnt          <= '0;
            r_ptr          <= '0;
            r_rvalid       <= '0;
            r_mem_soft_rst <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_ptr          <= w_ptr_next;
            // Only granted reads return data; writes stay silent.
            r_rvalid       <= w_gnt & ~we;
            // Pulse is registered off the kick state, so it lands on the
            // cycle after each kick (including the one forced by reset).
            r_mem_soft_rst <= (r_state == ST_RELOAD_KICK);
        end
    end

    // ------------------------------------------------------------------
    // Next-state / reload counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_SERVE: begin
                w_cnt_next = '0;
                if (reload_req) begin
                    w_state_next = ST_RELOAD_KICK;
                end
            end
            ST_RELOAD_KICK: begin
                w_cnt_next = '0;
                if (reload_req) begin
                    w_state_next = ST_RELOAD_KICK;
                end else begin
                    w_state_next = ST_RELOAD_WAIT;
                end
            end
            ST_RELOAD_WAIT: begin
                if (reload_req) begin
                    // A new request restarts the whole reload.
                    w_state_next = ST_RELOAD_KICK;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_SERVE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = ST_RELOAD_KICK;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------
    // reload_req wins over any pending access in the same cycle; rst is
    // included so nothing is issued while reset is being applied.
    assign w_grant_en = (r_state == ST_SERVE) && !reload_req && !rst;

    // Slot examined at search offset gi, starting from the pointer.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rr
            assign w_rr_idx[gi] = PW'((int'(r_ptr) + gi) % NUM_REQ);
        end
    endgenerate

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (!w_found && req[w_rr_idx[o]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_rr_idx[o];
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_grant_en && w_found) begin
            w_gnt = NUM_REQ'(1) << w_gnt_idx;
        end
    end

    always_comb begin
        w_ptr_next = r_ptr;
        if (w_gnt != '0) begin
            w_ptr_next = (w_gnt_idx == PTR_LAST) ? '0 : w_gnt_idx + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // BRAM port drive: AND-OR mux on the one-hot grant, so the port is
    // all zero whenever nothing is granted.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
            assign w_addr_m[gi] = addr[gi*AW +: AW] & {AW{w_gnt[gi]}};
            assign w_di_m[gi]   = wdata[gi*DATA_WIDTH +: DATA_WIDTH]
                                  & {DATA_WIDTH{w_gnt[gi]}};
            assign w_we_m[gi]   = we[gi] & w_gnt[gi];
        end
    endgenerate

    always_comb begin
        ram_addr = '0;
        ram_di   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ram_addr = ram_addr | w_addr_m[i];
            ram_di   = ram_di   | w_di_m[i];
        end
    end

    assign ram_we       = |w_we_m;
    assign gnt          = w_gnt;
    assign rvalid       = r_rvalid;
    assign rdata        = ram_do;
    assign busy         = (r_state != ST_SERVE);
    assign mem_soft_rst = r_mem_soft_rst;

endmodule

// File: tb/tb_map_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_map_port_arbiter
//
// Directed bench for map_port_arbiter with default parameters. A small
// read-first BRAM model sits on the ram_* port; on mem_soft_rst it restores
// the init image mem[a] = a[3:0].
// ---------------------------------------------------------------------------
module tb_map_port_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 4;
    localparam int DATA_DEPTH = 1023;
    localparam int AW         = $clog2(DATA_DEPTH);

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          reload_req;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*AW-1:0]         addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;
    logic                          ram_we;
    logic [AW-1:0]                 ram_addr;
    logic [DATA_WIDTH-1:0]         ram_di;
    logic [DATA_WIDTH-1:0]         ram_do;
    logic                          mem_soft_rst;

    int errors = 0;
    int checks = 0;

    map_port_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .DATA_DEPTH(DATA_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reload_req  (reload_req),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .busy        (busy),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_do      (ram_do),
        .mem_soft_rst(mem_soft_rst)
    );

    always #5 clk = ~clk;

    // Read-first BRAM model with one-cycle read latency.
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    always @(posedge clk) begin
        if (mem_soft_rst) begin
            for (int a = 0; a < DATA_DEPTH; a++) begin
                mem[a] <= DATA_WIDTH'(a);
            end
        end else if (ram_we) begin
            mem[ram_addr] <= ram_di;
        end
        ram_do <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_REQ*AW-1:0] pack_addr(input int a0, input int a1,
                                                        input int a2, input int a3);
        logic [NUM_REQ*AW-1:0] v;
        v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        return v;
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [3:0] we;
        logic [3:0] gnt;
        logic       rwe;
        logic [9:0] raddr;
        logic [3:0] rdi;
        logic [3:0] rv;
        logic [3:0] rd;
    } vec_t;

    vec_t tv [12];

    // Reload phase: counts busy cycles, mem_soft_rst cycles and any grants,
    // stopping at the first idle sample (left sitting on that negedge).
    task automatic run_reload(output int busy_n, output int msr_n, output int gnt_bad);
        busy_n  = 0;
        msr_n   = 0;
        gnt_bad = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_n++;
            if (mem_soft_rst) msr_n++;
            if (gnt != '0) gnt_bad++;
        end
    endtask

    logic [NUM_REQ*AW-1:0]         a_base;
    logic [NUM_REQ*DATA_WIDTH-1:0] w_base;
    logic [3:0] seq_g  [5];
    logic [3:0] seq_rv [5];
    logic [3:0] seq_rd [5];

    initial begin
        int bn, mn, gb;

        a_base = pack_addr(10, 11, 5, 13);
        w_base = {4'h4, 4'hA, 4'h2, 4'h1};

        // req, we, gnt, ram_we, ram_addr, ram_di, rvalid, rdata
        tv[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 10'd0,  4'h0, 4'b0001, 4'h1};
        tv[1]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 10'd5,  4'hA, 4'b0000, 4'h0};
        tv[2]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 10'd5,  4'hA, 4'b0000, 4'h0};
        tv[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 10'd0,  4'h0, 4'b0100, 4'hA};
        tv[4]  = '{4'b0011, 4'b0011, 4'b0001, 1'b1, 10'd10, 4'h1, 4'b0000, 4'h0};
        tv[5]  = '{4'b0011, 4'b0010, 4'b0010, 1'b1, 10'd11, 4'h2, 4'b0000, 4'h0};
        tv[6]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 10'd10, 4'h1, 4'b0000, 4'h0};
        tv[7]  = '{4'b1000, 4'b0000, 4'b1000, 1'b0, 10'd13, 4'h4, 4'b0001, 4'h1};
        tv[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 10'd0,  4'h0, 4'b1000, 4'hD};
        tv[9]  = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 10'd11, 4'h2, 4'b0000, 4'h0};
        tv[10] = '{4'b1111, 4'b0000, 4'b0100, 1'b0, 10'd5,  4'hA, 4'b0010, 4'h2};
        tv[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 10'd0,  4'h0, 4'b0100, 4'hA};

        seq_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_rv = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        seq_rd = '{4'h0,    4'h1,    4'h2,    4'h3,    4'h4};

        // ---------------- reset and automatic reload ----------------
        rst        = 1'b1;
        reload_req = 1'b0;
        req        = 4'b1111;
        we         = 4'b0000;
        addr       = pack_addr(1, 2, 3, 4);
        wdata      = w_base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   64'(busy), 64'(1));
        chk("rst_gnt",    64'(gnt), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_msr",    64'(mem_soft_rst), 64'(0));
        chk("rst_ram_we", 64'(ram_we), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_reload(bn, mn, gb);
        chk("boot_busy_cycles", 64'(bn), 64'(1025));
        chk("boot_msr_pulses",  64'(mn), 64'(1));
        chk("boot_gnt_blocked", 64'(gb), 64'(0));

        // ---------------- round-robin with all requesting ------------
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("rr_gnt[%0d]", k), 64'(gnt), 64'(seq_g[k]));
            chk($sformatf("rr_rvalid[%0d]", k), 64'(rvalid), 64'(seq_rv[k]));
            if (seq_rv[k] != 4'b0000)
                chk($sformatf("rr_rdata[%0d]", k), 64'(rdata), 64'(seq_rd[k]));
        end

        // ---------------- table-driven vectors ------------------------
        for (int i = 0; i < 12; i++) begin
            step();
            req   = tv[i].req;
            we    = tv[i].we;
            addr  = a_base;
            wdata = w_base;
            @(negedge clk);
            chk($sformatf("tv%0d_gnt", i),    64'(gnt),      64'(tv[i].gnt));
            chk($sformatf("tv%0d_ram_we", i), 64'(ram_we),   64'(tv[i].rwe));
            chk($sformatf("tv%0d_addr", i),   64'(ram_addr), 64'(tv[i].raddr));
            chk($sformatf("tv%0d_di", i),     64'(ram_di),   64'(tv[i].rdi));
            chk($sformatf("tv%0d_rvalid", i), 64'(rvalid),   64'(tv[i].rv));
            if (tv[i].rv != 4'b0000)
                chk($sformatf("tv%0d_rdata", i), 64'(rdata), 64'(tv[i].rd));
            $display("vector %0d: req=%b we=%b gnt=%b rvalid=%b rdata=%h",
                     i, req, we, gnt, rvalid, rdata);
        end

        // ---------------- read grant then reload ----------------------
        step();
        req = 4'b0001;
        we  = 4'b0000;
        @(negedge clk);
        chk("ra_gnt", 64'(gnt), 64'(4'b0001));
        step();
        reload_req = 1'b1;
        @(negedge clk);
        chk("rb_gnt_blocked", 64'(gnt), 64'(0));
        chk("rb_busy",        64'(busy), 64'(0));
        chk("rb_rvalid",      64'(rvalid), 64'(4'b0001));
        chk("rb_rdata",       64'(rdata), 64'(4'h1));
        step();
        reload_req = 1'b0;
        @(negedge clk);
        chk("rc_busy", 64'(busy), 64'(1));
        chk("rc_gnt",  64'(gnt), 64'(0));
        mn = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clk);
            if (mem_soft_rst) mn++;
        end
        chk("reload1_msr_pulses", 64'(mn), 64'(1));
        step();
        reload_req = 1'b1;
        @(negedge clk);
        chk("restart_busy", 64'(busy), 64'(1));
        step();
        reload_req = 1'b0;
        run_reload(bn, mn, gb);
        chk("restart_busy_cycles", 64'(bn), 64'(1025));
        chk("restart_msr_pulses",  64'(mn), 64'(1));
        chk("restart_gnt_blocked", 64'(gb), 64'(0));
        chk("post_reload_gnt",     64'(gnt), 64'(4'b0001));

        // ---------------- reset during an access ----------------------
        step();
        rst = 1'b1;
        req = 4'b0010;
        we  = 4'b0000;
        @(negedge clk);
        chk("rst_access_gnt",  64'(gnt), 64'(0));
        chk("rst_access_addr", 64'(ram_addr), 64'(0));
        step();
        @(negedge clk);
        chk("rst_access_rvalid", 64'(rvalid), 64'(0));
        chk("rst_access_busy",   64'(busy), 64'(1));
        chk("rst_access_msr",    64'(mem_soft_rst), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
